// File: rtl/cprv_ifetch.sv
// cprv_ifetch: PC generation, word reads with two in flight, 2-entry instruction buffer; CPRV_IFETCH_MISALIGN_TRAP_EN adds the misaligned-target fault.
// Latency: a response accepted in cycle N reaches decode in N+1; a redirect empties the buffer for N+1.
// Backpressure: requests stall while pending + occ + discard reaches 2; a raised request is held until ready_imem.

// Two-entry FIFO with synchronous clear; callers guarantee no push when full and no pop when empty.
module cprv_ifetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else if (clr) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_dat;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_dat = mem[rptr];
endmodule

module cprv_ifetch #(
  parameter int          DATA_WIDTH = 64,
  parameter int          ADDR_WIDTH = 7,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  valid_imem,
  input  logic                  ready_imem,
  output logic [ADDR_WIDTH-1:0] instr_addr_imem,
  input  logic                  valid_if,
  output logic                  ready_if,
  input  logic [DATA_WIDTH-1:0] instr_data_imem,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_o,
  output logic [63:0]           pc_o,
  input  logic                  redirect_i,
  input  logic [63:0]           redirect_pc_i
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_fault_o
`endif
);
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ibuf_ent_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
    ,
    S_FAULT
`endif
  } state_t;

  state_t                state, state_nxt;
  logic                  req_hs, rsp_hs, rsp_live, fetch_en;
  logic [2:0]            credits, discard_sum;
  logic [1:0]            discard, discard_nxt, pending, occ;
  logic [63:0]           fpc, tgt, tag_head;
  logic                  stale;
  logic [ADDR_WIDTH-1:0] stale_addr;
  ibuf_ent_t             buf_in, buf_head;

  assign ready_if   = rst_n;
  assign req_hs     = valid_imem && ready_imem;
  assign rsp_hs     = valid_if && ready_if;
  assign rsp_live   = rsp_hs && (discard == 2'd0) && !redirect_i;
  assign credits    = {1'b0, pending} + {1'b0, occ} + {1'b0, discard};
  assign fetch_en   = (state == S_RUN) && (credits < 3'd2);
  // A request raised before a redirect stays on the bus; its response is counted as stale.
  assign valid_imem = stale || fetch_en;
  assign instr_addr_imem = stale ? stale_addr : (fetch_en ? fpc[ADDR_WIDTH+2:3] : '0);
  assign tgt        = redirect_pc_i & ~64'h3;

`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
  logic        misalign;
  logic [63:0] fault_pc;
  assign misalign = (redirect_pc_i[1:0] != 2'b00);
`endif

  always_comb begin
    state_nxt   = state;
    discard_sum = {1'b0, discard};
    if (redirect_i)
      discard_sum = {1'b0, discard} + {1'b0, pending} + {2'b0, req_hs} - {2'b0, rsp_hs};
    else
      discard_sum = {1'b0, discard} + {2'b0, req_hs && stale}
                    - {2'b0, rsp_hs && (discard != 2'd0)};
    discard_nxt = discard_sum[1:0];
    case (state)
      S_IDLE:  state_nxt = S_RUN;
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
      S_RUN:   if (redirect_i && misalign) state_nxt = S_FAULT;
      S_FAULT: if (redirect_i && !misalign) state_nxt = S_RUN;
`endif
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc        <= RESET_PC;
      discard    <= 2'd0;
      stale      <= 1'b0;
      stale_addr <= '0;
    end else begin
      discard <= discard_nxt;
      if (redirect_i)                   fpc <= tgt;
      else if (req_hs && !stale)        fpc <= fpc + 64'd4;
      if (redirect_i && valid_imem && !ready_imem) begin
        stale      <= 1'b1;
        stale_addr <= instr_addr_imem;
      end else if (req_hs) begin
        stale <= 1'b0;
      end
    end
  end

  cprv_ifetch_fifo #(.W(64)) u_tagq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (redirect_i),
    .push     (req_hs && !stale && !redirect_i),
    .push_dat (fpc),
    .pop      (rsp_live),
    .head_dat (tag_head),
    .cnt      (pending)
  );

  assign buf_in.instr = tag_head[2] ? instr_data_imem[63:32] : instr_data_imem[31:0];
  assign buf_in.pc    = tag_head;

  cprv_ifetch_fifo #(.W($bits(ibuf_ent_t))) u_ibuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (redirect_i),
    .push     (rsp_live),
    .push_dat (buf_in),
    .pop      (instr_valid_o && instr_ready_i),
    .head_dat (buf_head),
    .cnt      (occ)
  );

  assign instr_valid_o = (occ != 2'd0);
  assign instr_o       = buf_head.instr;

`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          fault_pc <= '0;
    else if (redirect_i) fault_pc <= redirect_pc_i;
  end
  assign fetch_fault_o = (state == S_FAULT);
  assign pc_o          = (state == S_FAULT) ? fault_pc : buf_head.pc;
`else
  assign pc_o          = buf_head.pc;
`endif
endmodule

// File: tb/tb_cprv_ifetch.sv
// Directed bench for cprv_ifetch with a behavioural instruction memory of configurable latency.
`timescale 1ns/1ps
module tb_cprv_ifetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_imem, ready_imem;
  logic [6:0]  instr_addr_imem;
  logic        valid_if, ready_if;
  logic [63:0] instr_data_imem;
  logic        instr_valid_o, instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
  logic        fetch_fault_o;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cprv_ifetch #(.DATA_WIDTH(64), .ADDR_WIDTH(7), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_imem      (valid_imem),
    .ready_imem      (ready_imem),
    .instr_addr_imem (instr_addr_imem),
    .valid_if        (valid_if),
    .ready_if        (ready_if),
    .instr_data_imem (instr_data_imem),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i)
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault_o   (fetch_fault_o)
`endif
  );

  // Memory: word 0 holds two real instructions, word w holds {C0DE,pc+4,C0DE,pc}.
  typedef struct packed {
    logic [31:0] due;
    logic [6:0]  addr;
  } req_t;
  req_t        req_q[$];
  logic [63:0] mem [128];
  int unsigned mem_cyc = 0;
  int unsigned req_cnt = 0;
  int unsigned lat = 1;

  initial begin
    req_t r;
    valid_if = 1'b0;
    instr_data_imem = '0;
    forever begin
      @(negedge clk);
      mem_cyc++;
      if (req_q.size() > 0 && req_q[0].due <= mem_cyc) begin
        valid_if = 1'b1;
        instr_data_imem = mem[req_q[0].addr];
        void'(req_q.pop_front());
      end else begin
        valid_if = 1'b0;
        instr_data_imem = '0;
      end
      #2;
      if (valid_imem && ready_imem) begin
        r.due  = mem_cyc + lat;
        r.addr = instr_addr_imem;
        req_q.push_back(r);
        req_cnt++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned l);
    rst_n = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b0;
    ready_imem = 1'b1;
    req_q.delete();
    lat = l;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_instr(output bit ok);
    ok = (instr_valid_o === 1'b1);
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      ok = (instr_valid_o === 1'b1);
    end
  endtask

  task automatic test_reset();
    step();
    n_total++; if (valid_imem !== 1'b0) $display("FAIL reset_valid_imem got %b expected 0", valid_imem); else n_pass++;
    n_total++; if (instr_addr_imem !== 7'd0) $display("FAIL reset_addr got %h expected 0", instr_addr_imem); else n_pass++;
    n_total++; if (ready_if !== 1'b0) $display("FAIL reset_ready_if got %b expected 0", ready_if); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL reset_instr_valid got %b expected 0", instr_valid_o); else n_pass++;
    n_total++; if (instr_o !== 32'h0) $display("FAIL reset_instr got %h expected 0", instr_o); else n_pass++;
    n_total++; if (pc_o !== 64'h0) $display("FAIL reset_pc got %h expected 0", pc_o); else n_pass++;
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
    n_total++; if (fetch_fault_o !== 1'b0) $display("FAIL reset_fault got %b expected 0", fetch_fault_o); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    do_reset(1);
    instr_ready_i = 1'b1;
    n_total++; if (valid_imem !== 1'b0) $display("FAIL basic_c0_valid_imem got %b expected 0", valid_imem); else n_pass++;
    step();
    n_total++; if (valid_imem !== 1'b1) $display("FAIL basic_c1_valid_imem got %b expected 1", valid_imem); else n_pass++;
    n_total++; if (instr_addr_imem !== 7'd0) $display("FAIL basic_c1_addr got %h expected 0", instr_addr_imem); else n_pass++;
    n_total++; if (ready_if !== 1'b1) $display("FAIL basic_ready_if got %b expected 1", ready_if); else n_pass++;
    step();
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL basic_c2_instr_valid got %b expected 0", instr_valid_o); else n_pass++;
    step();
    n_total++; if (instr_valid_o !== 1'b1) $display("FAIL basic_c3_instr_valid got %b expected 1", instr_valid_o); else n_pass++;
    n_total++; if (instr_o !== 32'h00100093) $display("FAIL basic_instr0 got %h expected 00100093", instr_o); else n_pass++;
    n_total++; if (pc_o !== 64'h0) $display("FAIL basic_pc0 got %h expected 0", pc_o); else n_pass++;
    n_total++; if (valid_imem !== 1'b0) $display("FAIL basic_c3_credit_stall got %b expected 0", valid_imem); else n_pass++;
    step();
    n_total++; if (instr_o !== 32'h00000013) $display("FAIL basic_instr1 got %h expected 00000013", instr_o); else n_pass++;
    n_total++; if (pc_o !== 64'h4) $display("FAIL basic_pc1 got %h expected 4", pc_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    int unsigned base;
    do_reset(1);
    base = req_cnt;
    repeat (10) step();
    n_total++; if (req_cnt - base !== 2) $display("FAIL bp_req_count got %0d expected 2", req_cnt - base); else n_pass++;
    n_total++; if (valid_imem !== 1'b0) $display("FAIL bp_valid_imem got %b expected 0", valid_imem); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b1) $display("FAIL bp_instr_valid got %b expected 1", instr_valid_o); else n_pass++;
    n_total++; if (pc_o !== 64'h0) $display("FAIL bp_head_pc got %h expected 0", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'h00100093) $display("FAIL bp_head_instr got %h expected 00100093", instr_o); else n_pass++;
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    n_total++; if (pc_o !== 64'h4) $display("FAIL bp_after_pop_pc got %h expected 4", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'h00000013) $display("FAIL bp_after_pop_instr got %h expected 00000013", instr_o); else n_pass++;
    n_total++; if (valid_imem !== 1'b1) $display("FAIL bp_after_pop_valid_imem got %b expected 1", valid_imem); else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    do_reset(3);
    instr_ready_i = 1'b1;
    step();
    step();
    step();
    n_total++; if (valid_imem !== 1'b0) $display("FAIL infl_two_pending got %b expected 0", valid_imem); else n_pass++;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h40;
    step();
    redirect_i = 1'b0;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL infl_instr_valid got %b expected 0", instr_valid_o); else n_pass++;
    n_total++; if (valid_imem !== 1'b0) $display("FAIL infl_discard_stall got %b expected 0", valid_imem); else n_pass++;
    wait_instr(ok);
    n_total++; if (!ok) $display("FAIL infl_timeout got instr_valid_o=0 expected 1"); else n_pass++;
    n_total++; if (pc_o !== 64'h40) $display("FAIL infl_pc got %h expected 40", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'hC0DE0040) $display("FAIL infl_instr got %h expected C0DE0040", instr_o); else n_pass++;
    step();
    wait_instr(ok);
    n_total++; if (pc_o !== 64'h44) $display("FAIL infl_pc_next got %h expected 44", pc_o); else n_pass++;
  endtask

  task automatic test_redirect_collide();
    bit ok;
    do_reset(1);
    instr_ready_i = 1'b1;
    repeat (3) step();
    n_total++; if (pc_o !== 64'h0) $display("FAIL coll_pre_pc got %h expected 0", pc_o); else n_pass++;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h80;
    step();
    redirect_i = 1'b0;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL coll_instr_valid got %b expected 0", instr_valid_o); else n_pass++;
    n_total++; if (valid_imem !== 1'b1) $display("FAIL coll_valid_imem got %b expected 1", valid_imem); else n_pass++;
    n_total++; if (instr_addr_imem !== 7'd16) $display("FAIL coll_addr got %h expected 10", instr_addr_imem); else n_pass++;
    wait_instr(ok);
    n_total++; if (pc_o !== 64'h80) $display("FAIL coll_pc got %h expected 80", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'hC0DE0080) $display("FAIL coll_instr got %h expected C0DE0080", instr_o); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    bit ok;
    do_reset(1);
    ready_imem = 1'b0;
    instr_ready_i = 1'b1;
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 64'h40;
    for (int i = 0; i < 6; i++) begin
      step();
      redirect_i = 1'b0;
      n_total++;
      if (valid_imem !== 1'b1 || instr_addr_imem !== 7'd0)
        $display("FAIL stall_hold cycle %0d got valid=%b addr=%h expected valid=1 addr=0", i, valid_imem, instr_addr_imem);
      else n_pass++;
    end
    ready_imem = 1'b1;
    step();
    wait_instr(ok);
    n_total++; if (pc_o !== 64'h40) $display("FAIL stall_pc got %h expected 40", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'hC0DE0040) $display("FAIL stall_instr got %h expected C0DE0040", instr_o); else n_pass++;
  endtask

  task automatic test_midreset();
    bit ok;
    do_reset(1);
    instr_ready_i = 1'b1;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    n_total++; if (valid_imem !== 1'b0) $display("FAIL mrst_valid_imem got %b expected 0", valid_imem); else n_pass++;
    n_total++; if (ready_if !== 1'b0) $display("FAIL mrst_ready_if got %b expected 0", ready_if); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL mrst_instr_valid got %b expected 0", instr_valid_o); else n_pass++;
    n_total++; if (pc_o !== 64'h0) $display("FAIL mrst_pc got %h expected 0", pc_o); else n_pass++;
    do_reset(1);
    instr_ready_i = 1'b1;
    wait_instr(ok);
    n_total++; if (pc_o !== 64'h0) $display("FAIL mrst_restart_pc got %h expected 0", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'h00100093) $display("FAIL mrst_restart_instr got %h expected 00100093", instr_o); else n_pass++;
  endtask

`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
  task automatic test_fault();
    bit ok;
    int unsigned base;
    do_reset(1);
    instr_ready_i = 1'b1;
    step();
    redirect_i = 1'b1;
    redirect_pc_i = 64'h42;
    step();
    redirect_i = 1'b0;
    base = req_cnt;
    n_total++; if (fetch_fault_o !== 1'b1) $display("FAIL fault_set got %b expected 1", fetch_fault_o); else n_pass++;
    n_total++; if (valid_imem !== 1'b0) $display("FAIL fault_no_req got %b expected 0", valid_imem); else n_pass++;
    n_total++; if (pc_o !== 64'h42) $display("FAIL fault_pc got %h expected 42", pc_o); else n_pass++;
    n_total++; if (instr_valid_o !== 1'b0) $display("FAIL fault_instr_valid got %b expected 0", instr_valid_o); else n_pass++;
    repeat (3) step();
    n_total++; if (req_cnt - base !== 0) $display("FAIL fault_req_count got %0d expected 0", req_cnt - base); else n_pass++;
    redirect_i = 1'b1;
    redirect_pc_i = 64'h80;
    step();
    redirect_i = 1'b0;
    n_total++; if (fetch_fault_o !== 1'b0) $display("FAIL fault_clear got %b expected 0", fetch_fault_o); else n_pass++;
    n_total++; if (valid_imem !== 1'b1 || instr_addr_imem !== 7'd16)
      $display("FAIL fault_resume_req got valid=%b addr=%h expected valid=1 addr=10", valid_imem, instr_addr_imem);
    else n_pass++;
    wait_instr(ok);
    n_total++; if (pc_o !== 64'h80) $display("FAIL fault_resume_pc got %h expected 80", pc_o); else n_pass++;
    n_total++; if (instr_o !== 32'hC0DE0080) $display("FAIL fault_resume_instr got %h expected C0DE0080", instr_o); else n_pass++;
  endtask
`endif

  initial begin
    ready_imem = 1'b1;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    mem[0] = 64'h00000013_00100093;
    for (int w = 1; w < 128; w++)
      mem[w] = {16'hC0DE, 16'(w * 8 + 4), 16'hC0DE, 16'(w * 8)};
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_redirect_stall();
    test_midreset();
`ifdef CPRV_IFETCH_MISALIGN_TRAP_EN
    test_fault();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
